sync_fifo: RTL and testbench
============================

# sync_fifo

Parametrised synchronous first-word-fall-through FIFO with occupancy count, programmable almost-full and almost-empty thresholds, sticky overflow and underflow flags, and a synchronous flush. It is the general-purpose buffer for streaming paths inside a single clock domain, and it supersedes fixed-configuration array FIFOs. It is a storage block only: flow control is the caller's responsibility, and misuse is recorded in the sticky flags rather than prevented.

## Interface
- DATA_WIDTH, default 8: width of one entry.
- LOG_DEPTH, default 3: DEPTH = 2**LOG_DEPTH entries; legal range 1..12.
- ALMOST_FULL, default 2**LOG_DEPTH-1: almost_full asserts when count >= ALMOST_FULL; legal range 1..DEPTH.
- ALMOST_EMPTY, default 1: almost_empty asserts when count <= ALMOST_EMPTY; legal range 0..DEPTH-1.

Ports:
- clock  in  1  rising-edge clock; the only clock in the block.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush; takes priority over rreq and wreq.
- wreq  in  1  write request.
- wdata  in  DATA_WIDTH  write data.
- rreq  in  1  read request; pops the head entry.
- rdata  out  DATA_WIDTH  head entry (first-word fall-through).
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_empty  out  1  count <= ALMOST_EMPTY.
- almost_full  out  1  count >= ALMOST_FULL.
- count  out  LOG_DEPTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; set by a rejected write.
- underflow  out  1  sticky; set by a rejected read.

## Operation
- Storage: DEPTH x DATA_WIDTH array, not reset. The array has no read port other than rdata.
- Pointers: head and tail, each LOG_DEPTH bits, wrap modulo DEPTH through natural overflow. count is LOG_DEPTH+1 bits. tail == head means either empty or full; count disambiguates.
- Accepted write (wa): wreq && (!full || rreq).
  - Effect: mem[tail] <= wdata, tail <= tail+1.
- Accepted read (ra): rreq && !empty.
  - Effect: head <= head+1.
- Count update:
  - wa && !ra: count+1.
  - ra && !wa: count-1.
  - Both or neither: unchanged.
- Full plus simultaneous rreq/wreq: both are accepted, and count stays DEPTH.
- Empty plus simultaneous rreq/wreq: the write is accepted, the read is rejected, underflow is set, and count becomes 1. There is no bypass from wdata to rdata.
- Rejected write (wreq && full && !rreq): memory is not modified, overflow <= 1.
- Rejected read (rreq && empty): underflow <= 1.
- clear: head, tail and count all go to 0. wreq and rreq in the same cycle are ignored, and the flags are not set by them. overflow and underflow are cleared.
- rdata = mem[head], combinational from the registered pointer. rdata is undefined while empty, and benches must not check it then.
- Status outputs are combinational functions of the registered count.

## Timing
- Reset asserted:
  - Immediately, with no clock edge needed: head=0, tail=0, count=0, empty=1, full=0, almost_full=0, overflow=0, underflow=0.
  - almost_empty=1 because 0 <= ALMOST_EMPTY.
- Reset mid-operation discards all contents, and the state above holds until reset deasserts.
- First usable edge: the first rising edge after reset deassertion.
- Write-to-read latency:
  - A word written at edge N appears on rdata, with empty=0, after edge N, and can be popped at edge N+1.
- Read:
  - rreq is sampled at the edge.
  - rdata shows the current head before that edge, and the next entry after it.
- Count and all status outputs update on the same edge as the accepted operation.
- Sticky flags set on the edge of the offending request and stay set until reset or clear.

## Test plan
All scenarios use DATA_WIDTH=8, LOG_DEPTH=2, ALMOST_FULL=3, ALMOST_EMPTY=1.

- **Reset values:** assert reset with no clock running -> count=0, empty=1, almost_empty=1, full=0, overflow=0, underflow=0.
- **Fill then drain:** write 0x11, 0x22, 0x33, 0x44 on four edges.
  - During the fill: almost_empty drops when count=2, almost_full rises when count=3, full=1 when count=4.
  - Drain with four reads: rdata shows 0x11, 0x22, 0x33, 0x44 in order, and the block ends with empty=1.
- **Overflow:** with the FIFO full, wreq alone with 0x55 -> overflow=1, count stays 4, and the next reads return 0x11 through 0x44 (0x55 never appears).
- **Full with simultaneous rreq/wreq:** when full, assert rreq and wreq with 0x66 -> count stays 4, rdata becomes 0x22, and 0x66 is read out last, so pointer wrap-around is exercised.
- **Empty with simultaneous rreq/wreq:** when empty, assert rreq and wreq with 0x77 -> underflow=1, count=1, rdata=0x77.
- **Flush and mid-operation reset:**
  - With count=3 and both sticky flags set, pulse clear together with wreq -> count=0, empty=1, flags cleared, and the write is discarded.
  - Refill to count=2, then assert reset between edges -> count=0 and empty=1 immediately, before the next edge.

Source files
------------

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO with occupancy count,
// programmable almost-full / almost-empty thresholds, sticky overflow and
// underflow flags and a synchronous flush. Flow control belongs to the
// caller; misuse is recorded in the sticky flags, not prevented.
module sync_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int LOG_DEPTH    = 3,
    parameter int ALMOST_FULL  = 2**LOG_DEPTH - 1,
    parameter int ALMOST_EMPTY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  wreq,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rreq,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [LOG_DEPTH:0]    count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH    = 2**LOG_DEPTH;
    localparam int CNT_W    = LOG_DEPTH + 1;

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(ALMOST_FULL);
    localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(ALMOST_EMPTY);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [LOG_DEPTH-1:0]  head;
    logic [LOG_DEPTH-1:0]  tail;

    logic wr_accept;
    logic rd_accept;
    logic wr_reject;
    logic rd_reject;

    // A write is accepted when there is room, or when a simultaneous read
    // frees the slot; a read is accepted whenever there is a head entry.
    assign wr_accept = wreq && (!full || rreq);
    assign rd_accept = rreq && !empty;
    assign wr_reject = wreq && full && !rreq;
    assign rd_reject = rreq && empty;

    // Status is derived from the registered count only.
    assign empty        = (count == '0);
    assign full         = (count == DEPTH_CNT);
    assign almost_empty = (count <= AE_CNT);
    assign almost_full  = (count >= AF_CNT);

    // First-word fall-through: the head entry is always presented.
    assign rdata = mem[head];

    // Storage write port; a flush or reset suppresses the write.
    // NOTE: the array has no reset branch on purpose: its contents are only
    // observable through head/count, which are reset, so clearing it would
    // just cost a reset net per bit and block RAM inference.
    always_ff @(posedge clock) begin
        if (!reset && !clear && wr_accept) begin
            mem[tail] <= wdata;
        end
    end

    // Pointers, occupancy and sticky flags; clear overrides both requests.
    // NOTE: every register here uses non-blocking assignment so all updates
    // see the pre-edge values of count/full/empty, regardless of order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                tail <= tail + LOG_DEPTH'(1);
            end
            if (rd_accept) begin
                head <= head + LOG_DEPTH'(1);
            end
            if (wr_accept && !rd_accept) begin
                count <= count + CNT_W'(1);
            end else if (rd_accept && !wr_accept) begin
                count <= count - CNT_W'(1);
            end
            if (wr_reject) begin
                overflow <= 1'b1;
            end
            if (rd_reject) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed bench for sync_fifo with DATA_WIDTH=8, LOG_DEPTH=2,
// ALMOST_FULL=3, ALMOST_EMPTY=1. Inputs change 1 time unit after a rising
// edge; outputs are sampled at that same point, away from the edge.
module tb_sync_fifo;

    logic       clock;
    logic       reset;
    logic       clear;
    logic       wreq;
    logic [7:0] wdata;
    logic       rreq;
    logic [7:0] rdata;
    logic       empty;
    logic       full;
    logic       almost_empty;
    logic       almost_full;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    sync_fifo #(
        .DATA_WIDTH  (8),
        .LOG_DEPTH   (2),
        .ALMOST_FULL (3),
        .ALMOST_EMPTY(1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .clear       (clear),
        .wreq        (wreq),
        .wdata       (wdata),
        .rreq        (rreq),
        .rdata       (rdata),
        .empty       (empty),
        .full        (full),
        .almost_empty(almost_empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    // Clock held low for the first 20 units so reset is seen with no clock.
    initial begin
        clock = 1'b0;
        #20;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        wreq  = 1'b0;
        rreq  = 1'b0;
        wdata = 8'h00;

        // Reset with no clock running.
        #3;
        check("rst_count",    32'(count),        32'd0);
        check("rst_empty",    32'(empty),        32'd1);
        check("rst_aempty",   32'(almost_empty), 32'd1);
        check("rst_full",     32'(full),         32'd0);
        check("rst_afull",    32'(almost_full),  32'd0);
        check("rst_overflow", 32'(overflow),     32'd0);
        check("rst_underflow",32'(underflow),    32'd0);
        #9;
        reset = 1'b0;

        // Fill with 11,22,33,44.
        tick();
        wreq = 1'b1; wdata = 8'h11;
        tick();
        check("fill1_count",  32'(count),        32'd1);
        check("fill1_empty",  32'(empty),        32'd0);
        check("fill1_aempty", 32'(almost_empty), 32'd1);
        check("fill1_rdata",  32'(rdata),        32'h11);
        wdata = 8'h22;
        tick();
        check("fill2_count",  32'(count),        32'd2);
        check("fill2_aempty", 32'(almost_empty), 32'd0);
        check("fill2_afull",  32'(almost_full),  32'd0);
        wdata = 8'h33;
        tick();
        check("fill3_count",  32'(count),        32'd3);
        check("fill3_afull",  32'(almost_full),  32'd1);
        check("fill3_full",   32'(full),         32'd0);
        wdata = 8'h44;
        tick();
        check("fill4_count",  32'(count),        32'd4);
        check("fill4_full",   32'(full),         32'd1);
        check("fill4_rdata",  32'(rdata),        32'h11);

        // Rejected write while full.
        wdata = 8'h55;
        tick();
        check("ovf_flag",     32'(overflow),     32'd1);
        check("ovf_count",    32'(count),        32'd4);
        check("ovf_rdata",    32'(rdata),        32'h11);

        // Full with simultaneous read and write: 11 popped, 66 enters at slot 0.
        rreq = 1'b1; wdata = 8'h66;
        tick();
        check("fullrw_count", 32'(count),        32'd4);
        check("fullrw_rdata", 32'(rdata),        32'h22);
        check("fullrw_ovf",   32'(overflow),     32'd1);

        // Drain: 22 (shown), 33, 44, 66; 55 must never appear.
        wreq = 1'b0;
        tick();
        check("drain1_rdata", 32'(rdata),        32'h33);
        check("drain1_count", 32'(count),        32'd3);
        check("drain1_full",  32'(full),         32'd0);
        tick();
        check("drain2_rdata", 32'(rdata),        32'h44);
        check("drain2_count", 32'(count),        32'd2);
        tick();
        check("drain3_rdata", 32'(rdata),        32'h66);
        check("drain3_count", 32'(count),        32'd1);
        check("drain3_aempty",32'(almost_empty), 32'd1);
        tick();
        check("drain4_count", 32'(count),        32'd0);
        check("drain4_empty", 32'(empty),        32'd1);
        check("drain4_unf",   32'(underflow),    32'd0);

        // Empty with simultaneous read and write.
        wreq = 1'b1; wdata = 8'h77;
        tick();
        check("emptyrw_unf",  32'(underflow),    32'd1);
        check("emptyrw_count",32'(count),        32'd1);
        check("emptyrw_rdata",32'(rdata),        32'h77);
        check("emptyrw_empty",32'(empty),        32'd0);

        // Bring count to 3 with both flags set.
        rreq = 1'b0; wdata = 8'h88;
        tick();
        wdata = 8'h99;
        tick();
        check("preclr_count", 32'(count),        32'd3);
        check("preclr_ovf",   32'(overflow),     32'd1);
        check("preclr_unf",   32'(underflow),    32'd1);

        // Flush with a write (and a read) in the same cycle.
        clear = 1'b1; wreq = 1'b1; rreq = 1'b1; wdata = 8'hAA;
        tick();
        check("clr_count",    32'(count),        32'd0);
        check("clr_empty",    32'(empty),        32'd1);
        check("clr_ovf",      32'(overflow),     32'd0);
        check("clr_unf",      32'(underflow),    32'd0);
        clear = 1'b0; wreq = 1'b0; rreq = 1'b0;
        tick();
        check("postclr_count",32'(count),        32'd0);
        check("postclr_unf",  32'(underflow),    32'd0);

        // Refill to two entries; the first one after a flush starts at slot 0.
        wreq = 1'b1; wdata = 8'hBB;
        tick();
        wdata = 8'hCC;
        tick();
        wreq = 1'b0;
        check("refill_count", 32'(count),        32'd2);
        check("refill_rdata", 32'(rdata),        32'hBB);

        // Asynchronous reset between edges.
        #2;
        reset = 1'b1;
        #1;
        check("arst_count",   32'(count),        32'd0);
        check("arst_empty",   32'(empty),        32'd1);
        check("arst_aempty",  32'(almost_empty), 32'd1);
        tick();
        check("arst_hold",    32'(count),        32'd0);
        reset = 1'b0;
        tick();
        check("arst_after",   32'(count),        32'd0);
        check("arst_after_e", 32'(empty),        32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
